// File: rtl/vchess_pkg.sv
// Shared types and constants for the move-generator readout path.
// Default widths come from the PIECE_BITS / MAX_POSITIONS macros when the build defines them.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif

package vchess_pkg;

    localparam int PIECE_BITS_DEF    = `PIECE_BITS;
    localparam int BOARD_WIDTH_DEF   = PIECE_BITS_DEF * 64;
    localparam int MAX_POSITIONS_DEF = `MAX_POSITIONS;

    // RAM entry layout: {en_passant_col[3:0], castle_mask[3:0], white_to_move, board}
    localparam int ENTRY_META_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        CLEAR,
        WAIT_LOW
    } fetch_state_t;

    function automatic int entry_width(input int board_width);
        return board_width + ENTRY_META_BITS;
    endfunction

endpackage

// File: rtl/move_fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched positions with their index/last tags.
// Flush empties it in one cycle; stored data is left in place and only the pointers move.
module move_fetch_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/move_fetch.sv
// Walks the move-generator result RAM and streams each position downstream, then releases the generator.
// Optional MOVE_FETCH_STATS_EN adds stall_cycles / seq_count counters.
module move_fetch
    import vchess_pkg::*;
#(
    parameter int PIECE_WIDTH        = PIECE_BITS_DEF,
    parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
    parameter int MAX_POSITIONS      = MAX_POSITIONS_DEF,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          abort,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    input  logic [BOARD_WIDTH-1:0]        gen_board,
    input  logic                          gen_white_to_move,
    input  logic [3:0]                    gen_castle_mask,
    input  logic [3:0]                    gen_en_passant_col,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          clear_moves,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BOARD_WIDTH-1:0]        out_board,
    output logic                          out_white_to_move,
    output logic [3:0]                    out_castle_mask,
    output logic [3:0]                    out_en_passant_col,
    output logic [MAX_POSITIONS_LOG2-1:0] out_index,
    output logic                          out_last,
    output logic                          no_moves,
    output logic                          busy
`ifdef MOVE_FETCH_STATS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [15:0]                   seq_count
`endif
);

    localparam int ENTRY_WIDTH = entry_width(BOARD_WIDTH);
    localparam int FIFO_WIDTH  = ENTRY_WIDTH + MAX_POSITIONS_LOG2 + 1;
    localparam logic [MAX_POSITIONS_LOG2-1:0] IDX_ONE = 1;

    fetch_state_t                  state;
    fetch_state_t                  state_next;
    logic [MAX_POSITIONS_LOG2-1:0] cnt;
    logic [MAX_POSITIONS_LOG2-1:0] rd_ptr;
    logic [MAX_POSITIONS_LOG2-1:0] last_idx;
    logic                          inflight;
    logic                          start;
    logic                          issue;
    logic                          flush;
    logic                          push;
    logic                          pop;
    logic [2:0]                    occ_after_pop;
    logic [1:0]                    fifo_count;
    logic [FIFO_WIDTH-1:0]         fifo_head;
    logic [FIFO_WIDTH-1:0]         push_data;

    // Credits count the head leaving this cycle, so a steady pop lets a new read issue every cycle.
    always_comb begin
        start         = enable && moves_ready;
        last_idx      = cnt - IDX_ONE;
        pop           = out_valid && out_ready;
        occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        flush         = abort && ((state == FETCH) || (state == DRAIN));
        issue         = (state == FETCH) && !abort && (rd_ptr < cnt) && (occ_after_pop < 3'd2);
        push          = inflight && !flush;
        push_data     = {gen_en_passant_col, gen_castle_mask, gen_white_to_move, gen_board,
                         move_index, (move_index == last_idx)};
    end

    always_comb begin
        state_next  = state;
        clear_moves = 1'b0;
        no_moves    = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (move_count == '0) begin
                        no_moves   = 1'b1;
                        state_next = CLEAR;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_next = CLEAR;
                end else if (issue && (rd_ptr == last_idx)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || ((fifo_count == 2'd0) && !inflight)) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clear_moves = 1'b1;
                state_next  = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!moves_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The RAM answers the cycle after move_index updates, so inflight simply trails issue by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_ptr     <= '0;
            move_index <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if ((state == IDLE) && start) begin
                cnt    <= move_count;
                rd_ptr <= '0;
            end else if (issue) begin
                move_index <= rd_ptr;
                rd_ptr     <= rd_ptr + IDX_ONE;
            end
        end
    end

    move_fetch_fifo #(
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);

    // Head fields are forced to zero while empty so stale FIFO contents never reach the stream.
    always_comb begin
        {out_en_passant_col, out_castle_mask, out_white_to_move, out_board, out_index, out_last} =
            out_valid ? fifo_head : '0;
    end

`ifdef MOVE_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            seq_count    <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                stall_cycles <= '0;
            end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (state == CLEAR) begin
                seq_count <= seq_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_move_fetch.sv
// Randomized bench for move_fetch: a RAM model feeds the generator side and each sequence is
// checked against the expected ordered list of entries, pulse counts and timing.
module tb_move_fetch;
    import vchess_pkg::*;

    localparam int BW   = BOARD_WIDTH_DEF;
    localparam int MAXP = MAX_POSITIONS_DEF;
    localparam int LW   = $clog2(MAXP);
    localparam int EW   = BW + ENTRY_META_BITS;
    localparam int RW   = ((EW + 31) / 32) * 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          abort;
    logic          moves_ready;
    logic [LW-1:0] move_count;
    logic [BW-1:0] gen_board;
    logic          gen_white_to_move;
    logic [3:0]    gen_castle_mask;
    logic [3:0]    gen_en_passant_col;
    logic [LW-1:0] move_index;
    logic          clear_moves;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_board;
    logic          out_white_to_move;
    logic [3:0]    out_castle_mask;
    logic [3:0]    out_en_passant_col;
    logic [LW-1:0] out_index;
    logic          out_last;
    logic          no_moves;
    logic          busy;
`ifdef MOVE_FETCH_STATS_EN
    logic [31:0]   stall_cycles;
    logic [15:0]   seq_count;
`endif

    logic [EW-1:0] ram [MAXP];
    int            checks = 0;
    int            errors = 0;
    int            seqs_done = 0;

    always #5 clk = ~clk;

    // Generator RAM model: data for move_index is visible the cycle after the address updates.
    assign {gen_en_passant_col, gen_castle_mask, gen_white_to_move, gen_board} = ram[move_index];

    move_fetch dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .abort              (abort),
        .moves_ready        (moves_ready),
        .move_count         (move_count),
        .gen_board          (gen_board),
        .gen_white_to_move  (gen_white_to_move),
        .gen_castle_mask    (gen_castle_mask),
        .gen_en_passant_col (gen_en_passant_col),
        .move_index         (move_index),
        .clear_moves        (clear_moves),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_board          (out_board),
        .out_white_to_move  (out_white_to_move),
        .out_castle_mask    (out_castle_mask),
        .out_en_passant_col (out_en_passant_col),
        .out_index          (out_index),
        .out_last           (out_last),
        .no_moves           (no_moves),
        .busy               (busy)
`ifdef MOVE_FETCH_STATS_EN
        ,
        .stall_cycles       (stall_cycles),
        .seq_count          (seq_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one full fetch sequence. mode: 0 ready high, 1 ready on every third cycle,
    // 2 random ready, 3 exactly three stall cycles then ready.
    task automatic applyStimulus(input int cnt, input int mode, input int abort_at,
                                 input int hold, input bit drop_mr);
        int            xfers, clears, nm, stalls, hold_left;
        int            first_busy, first_valid, first_x, last_x, clear_cyc, nm_cyc, n_exp;
        bit            done, abort_done, abort_now, prev_stall, in_hold;
        logic [RW-1:0] tmp;
        for (int i = 0; i < MAXP; i++) begin
            for (int w = 0; w < RW / 32; w++) tmp[w*32 +: 32] = $urandom;
            ram[i] = tmp[EW-1:0];
        end
        xfers = 0; clears = 0; nm = 0; stalls = 0; hold_left = hold;
        first_busy = -1; first_valid = -1; first_x = -1; last_x = -1; clear_cyc = -1; nm_cyc = -1;
        done = 0; abort_done = 0; prev_stall = 0;
        n_exp = (abort_at >= 0) ? abort_at : cnt;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            enable    = 1'b1;
            abort_now = 1'b0;
            in_hold   = 1'b0;
            if (cyc == 0) begin
                moves_ready = 1'b1;
                move_count  = LW'(cnt);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (stalls >= 3);
            endcase
            if (abort_at >= 0 && !abort_done && clears == 0 && first_valid >= 0 && xfers == abort_at) begin
                abort_now = 1'b1;
                out_ready = 1'b0;
            end
            abort = abort_now;
            if (drop_mr && first_busy >= 0 && clears == 0) begin
                moves_ready = 1'b0;
                move_count  = LW'($urandom);
            end
            if (clears > 0) begin
                if (hold_left > 0) begin
                    moves_ready = 1'b1;
                    hold_left--;
                    in_hold = 1'b1;
                end else begin
                    moves_ready = 1'b0;
                end
            end
            #1;
            if (busy && first_busy < 0) first_busy = cyc;
            if (no_moves) begin nm++; nm_cyc = cyc; end
            if (clear_moves) begin clears++; clear_cyc = cyc; end
            if (in_hold) checkOutput("wait_low_busy", busy, 1'b1);
            if (prev_stall) checkOutput("stall_keeps_valid", out_valid, 1'b1);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (abort_done || xfers >= cnt) begin
                    checkOutput("spurious_valid", out_valid, 1'b0);
                end else begin
                    checkOutput("entry_data",
                                {out_en_passant_col, out_castle_mask, out_white_to_move, out_board},
                                ram[xfers]);
                    checkOutput("entry_index", out_index, xfers);
                    checkOutput("entry_last", out_last, (xfers == cnt - 1));
                    if (out_ready) begin
                        if (first_x < 0) first_x = cyc;
                        last_x = cyc;
                        xfers++;
                    end
                end
            end
            if (out_valid && !out_ready) stalls++;
            prev_stall = out_valid && !out_ready && !abort_now;
            if (abort_now) abort_done = 1'b1;
            if (clears > 0 && !busy) done = 1'b1;
        end
        abort = 1'b0;
        checkOutput("seq_done", done, 1'b1);
        checkOutput("delivered", xfers, n_exp);
        checkOutput("clear_pulses", clears, 1);
        checkOutput("no_moves_pulses", nm, (cnt == 0));
        if (cnt == 0) checkOutput("clear_after_no_moves", clear_cyc - nm_cyc, 1);
        else checkOutput("first_valid_latency", first_valid - first_busy, 2);
        if (mode == 0 && abort_at < 0 && cnt > 0) checkOutput("back_to_back", last_x - first_x, cnt - 1);
        seqs_done++;
`ifdef MOVE_FETCH_STATS_EN
        checkOutput("seq_count", seq_count, seqs_done);
        if (mode == 3) checkOutput("stall_cycles", stall_cycles, 3);
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc;
        reset = 1'b1; enable = 1'b0; abort = 1'b0; moves_ready = 1'b0;
        move_count = '0; out_ready = 1'b0;
        for (int i = 0; i < MAXP; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_valid", out_valid, 1'b0);
        checkOutput("reset_index", move_index, 0);
        checkOutput("reset_clear", clear_moves, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic five entries");
        applyStimulus(5, 0, -1, 0, 1'b0);
        $display("[TB] empty move list");
        applyStimulus(0, 0, -1, 0, 1'b0);
        $display("[TB] four entries with backpressure");
        applyStimulus(4, 1, -1, 0, 1'b0);
        $display("[TB] abort after two accepted");
        applyStimulus(6, 0, 2, 0, 1'b0);
        $display("[TB] moves_ready held after release");
        applyStimulus(3, 0, -1, 3, 1'b0);
        $display("[TB] single entry");
        applyStimulus(1, 0, -1, 0, 1'b0);
        $display("[TB] maximum count");
        applyStimulus(MAXP - 1, 0, -1, 0, 1'b0);
        $display("[TB] three stall cycles");
        applyStimulus(2, 3, -1, 0, 1'b0);
        $display("[TB] randomized sequences");
        for (int s = 0; s < 6; s++) begin
            rc = $urandom_range(1, 20);
            applyStimulus(rc, 2, -1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset while draining");
        @(negedge clk);
        enable = 1'b1; moves_ready = 1'b1; move_count = LW'(1); out_ready = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("drain_entry_queued", out_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; moves_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_board", out_board, 0);
        checkOutput("rst_meta", {out_en_passant_col, out_castle_mask, out_white_to_move, out_index, out_last}, 0);
        checkOutput("rst_pulses", {clear_moves, no_moves}, 0);
        checkOutput("rst_move_index", move_index, 0);
`ifdef MOVE_FETCH_STATS_EN
        checkOutput("rst_seq_count", seq_count, 0);
        checkOutput("rst_stall_cycles", stall_cycles, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
